sha256_round_ctrl: RTL and testbench

SHA256_ROUND_CTRL -- requirements
Module: sha256_round_ctrl

---
 rtl/sha256_round_ctrl.sv | 166 ++++++++++++++++
 tb/tb_sha256_round_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression round controller.
// Sequences one 512-bit block through IDLE -> INIT -> 64 x ROUNDS -> FINAL -> DONE.
// Outputs are decoded from the next state and registered, so each strobe is
// glitch-free and lines up with the state it belongs to.
module sha256_round_ctrl #(
  parameter int PREFETCH_K = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       block_valid,
  input  logic       first_block,
  input  logic       abort,
  output logic       ready,
  output logic       init_h,
  output logic       load_work,
  output logic       round_en,
  output logic [5:0] round_idx,
  output logic [5:0] k_addr,
  output logic       w_from_block,
  output logic       update_h,
  output logic       digest_valid,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_ROUNDS = 3'd2,
    S_FINAL  = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] t_q, t_d;
  logic       first_q, first_d;

  logic       ready_q, ready_d;
  logic       init_h_q, init_h_d;
  logic       load_work_q, load_work_d;
  logic       round_en_q, round_en_d;
  logic [5:0] round_idx_q, round_idx_d;
  logic [5:0] k_addr_q, k_addr_d;
  logic       w_from_block_q, w_from_block_d;
  logic       update_h_q, update_h_d;
  logic       digest_valid_q, digest_valid_d;
  logic       busy_q, busy_d;

  // Next-state logic: block acceptance, round counting and abort handling.
  always_comb begin
    state_d = state_q;
    t_d     = 6'd0;
    first_d = first_q;
    case (state_q)
      S_IDLE: begin
        // abort wins over a simultaneous block_valid
        if (block_valid && !abort) begin
          state_d = S_INIT;
          first_d = first_block;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_INIT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_ROUNDS;
        end
      end
      S_ROUNDS: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (t_q == 6'd63) begin
          state_d = S_FINAL;
        end else begin
          state_d = S_ROUNDS;
          t_d     = t_q + 6'd1;
        end
      end
      S_FINAL: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // a block offered here is only taken once back in IDLE
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        first_d = 1'b0;
      end
    endcase
  end

  // Output decode from the upcoming state so the registered strobes match it.
  always_comb begin
    ready_d        = (state_d == S_IDLE);
    busy_d         = (state_d != S_IDLE);
    init_h_d       = (state_d == S_INIT) && first_d;
    load_work_d    = (state_d == S_INIT);
    round_en_d     = (state_d == S_ROUNDS);
    round_idx_d    = t_d;
    w_from_block_d = (state_d == S_ROUNDS) && (t_d[5:4] == 2'b00);
    update_h_d     = (state_d == S_FINAL);
    digest_valid_d = (state_d == S_DONE);
    k_addr_d       = 6'd0;
    if (state_d == S_ROUNDS) begin
      // a registered K table needs the address one round early
      if (PREFETCH_K != 0) begin
        k_addr_d = t_d + 6'd1;
      end else begin
        k_addr_d = t_d;
      end
    end else begin
      k_addr_d = 6'd0;
    end
  end

  // State, round counter, first-block flag and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      t_q            <= 6'd0;
      first_q        <= 1'b0;
      ready_q        <= 1'b1;
      busy_q         <= 1'b0;
      init_h_q       <= 1'b0;
      load_work_q    <= 1'b0;
      round_en_q     <= 1'b0;
      round_idx_q    <= 6'd0;
      k_addr_q       <= 6'd0;
      w_from_block_q <= 1'b0;
      update_h_q     <= 1'b0;
      digest_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      t_q            <= t_d;
      first_q        <= first_d;
      ready_q        <= ready_d;
      busy_q         <= busy_d;
      init_h_q       <= init_h_d;
      load_work_q    <= load_work_d;
      round_en_q     <= round_en_d;
      round_idx_q    <= round_idx_d;
      k_addr_q       <= k_addr_d;
      w_from_block_q <= w_from_block_d;
      update_h_q     <= update_h_d;
      digest_valid_q <= digest_valid_d;
    end
  end

  assign ready        = ready_q;
  assign busy         = busy_q;
  assign init_h       = init_h_q;
  assign load_work    = load_work_q;
  assign round_en     = round_en_q;
  assign round_idx    = round_idx_q;
  assign k_addr       = k_addr_q;
  assign w_from_block = w_from_block_q;
  assign update_h     = update_h_q;
  assign digest_valid = digest_valid_q;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Testbench for sha256_round_ctrl: two instances (PREFETCH_K=1 and 0) share
// stimulus; a cycle-count reference model checks every output each cycle.
module tb_sha256_round_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic block_valid = 1'b0;
  logic first_block = 1'b0;
  logic abort = 1'b0;

  logic       ready_p1, init_h_p1, load_work_p1, round_en_p1, w_from_block_p1;
  logic       update_h_p1, digest_valid_p1, busy_p1;
  logic [5:0] round_idx_p1, k_addr_p1;
  logic       ready_p0, init_h_p0, load_work_p0, round_en_p0, w_from_block_p0;
  logic       update_h_p0, digest_valid_p0, busy_p0;
  logic [5:0] round_idx_p0, k_addr_p0;

  int errors = 0;
  int checks = 0;
  logic mon_en = 1'b1;

  always #5 clk = ~clk;

  sha256_round_ctrl #(.PREFETCH_K(1)) u_p1 (
    .clk(clk), .rst_n(rst_n), .block_valid(block_valid), .first_block(first_block),
    .abort(abort), .ready(ready_p1), .init_h(init_h_p1), .load_work(load_work_p1),
    .round_en(round_en_p1), .round_idx(round_idx_p1), .k_addr(k_addr_p1),
    .w_from_block(w_from_block_p1), .update_h(update_h_p1),
    .digest_valid(digest_valid_p1), .busy(busy_p1)
  );

  sha256_round_ctrl #(.PREFETCH_K(0)) u_p0 (
    .clk(clk), .rst_n(rst_n), .block_valid(block_valid), .first_block(first_block),
    .abort(abort), .ready(ready_p0), .init_h(init_h_p0), .load_work(load_work_p0),
    .round_en(round_en_p0), .round_idx(round_idx_p0), .k_addr(k_addr_p0),
    .w_from_block(w_from_block_p0), .update_h(update_h_p0),
    .digest_valid(digest_valid_p0), .busy(busy_p0)
  );

  // Reference model: cycles since the accepted block (-1 = idle).
  // 0 = init, 1..64 = rounds 0..63, 65 = final, 66 = done.
  int   cnt = -1;
  logic m_first = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= -1;
      m_first <= 1'b0;
    end else if (cnt < 0) begin
      if (block_valid && !abort) begin
        cnt     <= 0;
        m_first <= first_block;
      end
    end else if (abort || cnt >= 66) begin
      cnt <= -1;
    end else begin
      cnt <= cnt + 1;
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_dut(input string tag, input int pf,
                         input logic rdy, input logic bsy, input logic ih, input logic lw,
                         input logic re, input logic [5:0] ri, input logic [5:0] ka,
                         input logic wfb, input logic uh, input logic dv);
    logic e_re;
    int   e_ri;
    int   e_ka;
    e_re = (cnt >= 1) && (cnt <= 64);
    e_ri = e_re ? cnt - 1 : 0;
    e_ka = (pf != 0) ? (e_re ? cnt % 64 : 0) : e_ri;
    check({tag, ".ready"}, 8'(rdy), 8'(cnt < 0));
    check({tag, ".busy"}, 8'(bsy), 8'(cnt >= 0));
    check({tag, ".init_h"}, 8'(ih), 8'((cnt == 0) && m_first));
    check({tag, ".load_work"}, 8'(lw), 8'(cnt == 0));
    check({tag, ".round_en"}, 8'(re), 8'(e_re));
    check({tag, ".round_idx"}, 8'(ri), 8'(e_ri));
    check({tag, ".k_addr"}, 8'(ka), 8'(e_ka));
    check({tag, ".w_from_block"}, 8'(wfb), 8'(e_re && (e_ri < 16)));
    check({tag, ".update_h"}, 8'(uh), 8'(cnt == 65));
    check({tag, ".digest_valid"}, 8'(dv), 8'(cnt == 66));
  endtask

  // Continuous comparison of both instances against the model.
  always @(negedge clk) begin
    if (mon_en) begin
      chk_dut("p1", 1, ready_p1, busy_p1, init_h_p1, load_work_p1, round_en_p1,
              round_idx_p1, k_addr_p1, w_from_block_p1, update_h_p1, digest_valid_p1);
      chk_dut("p0", 0, ready_p0, busy_p0, init_h_p0, load_work_p0, round_en_p0,
              round_idx_p0, k_addr_p0, w_from_block_p0, update_h_p0, digest_valid_p0);
    end
  end

  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  typedef struct packed {
    logic       bv;
    logic       fb;
    logic       ab;
    int         n;
    logic       rdy;
    logic       ih;
    logic       lw;
    logic       re;
    logic [5:0] ri;
    logic       uh;
    logic       dv;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int last_lw;
    int n_lw;
    int found;

    // Directed sequence: accept, rounds, final, done, DONE-ignores-valid, abort at 30.
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1,  1'b1, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1,  1'b1, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1,  1'b0, 1'b1, 1'b1, 1'b0, 6'd0,  1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b0, 1'b1, 6'd0,  1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 15, 1'b0, 1'b0, 1'b0, 1'b1, 6'd15, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b0, 1'b1, 6'd16, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 47, 1'b0, 1'b0, 1'b0, 1'b1, 6'd63, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1,  1'b1, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b1, 1'b0, 6'd0,  1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 31, 1'b0, 1'b0, 1'b0, 1'b1, 6'd30, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1,  1'b1, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 2,  1'b1, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 1'b0};

    // Reset state is checked by the monitor while rst_n is low.
    cycle(3);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      block_valid = tbl[i].bv;
      first_block = tbl[i].fb;
      abort       = tbl[i].ab;
      cycle(tbl[i].n);
      check($sformatf("tbl%0d.ready", i), 8'(ready_p1), 8'(tbl[i].rdy));
      check($sformatf("tbl%0d.init_h", i), 8'(init_h_p1), 8'(tbl[i].ih));
      check($sformatf("tbl%0d.load_work", i), 8'(load_work_p1), 8'(tbl[i].lw));
      check($sformatf("tbl%0d.round_en", i), 8'(round_en_p1), 8'(tbl[i].re));
      check($sformatf("tbl%0d.round_idx", i), 8'(round_idx_p1), 8'(tbl[i].ri));
      check($sformatf("tbl%0d.update_h", i), 8'(update_h_p1), 8'(tbl[i].uh));
      check($sformatf("tbl%0d.digest_valid", i), 8'(digest_valid_p1), 8'(tbl[i].dv));
    end
    abort = 1'b0;

    // Back-to-back: block_valid held high gives one load_work every 68 cycles.
    block_valid = 1'b1;
    first_block = 1'b1;
    last_lw = -1;
    n_lw = 0;
    for (int c = 0; c < 200; c++) begin
      cycle(1);
      if (load_work_p1) begin
        if (last_lw >= 0) check("b2b.period", 8'(c - last_lw), 8'd68);
        last_lw = c;
        n_lw++;
      end
    end
    check("b2b.count", 8'(n_lw), 8'd3);
    block_valid = 1'b0;
    found = 0;
    for (int c = 0; c < 80 && !found; c++) begin
      if (ready_p1) found = 1;
      else cycle(1);
    end
    check("b2b.drain_timeout", 8'(found), 8'd1);

    // Reset asserted at round_idx 10: outputs drop immediately, block discarded.
    block_valid = 1'b1;
    first_block = 1'b1;
    cycle(1);
    block_valid = 1'b0;
    found = 0;
    for (int c = 0; c < 80 && !found; c++) begin
      if (round_en_p1 && round_idx_p1 == 6'd10) found = 1;
      else cycle(1);
    end
    check("rst.wait_idx10", 8'(found), 8'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst.ready", 8'(ready_p1), 8'd1);
    check("rst.busy", 8'(busy_p1), 8'd0);
    check("rst.round_en", 8'(round_en_p1), 8'd0);
    check("rst.round_idx", 8'(round_idx_p1), 8'd0);
    check("rst.k_addr", 8'(k_addr_p1), 8'd0);
    check("rst.w_from_block", 8'(w_from_block_p1), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(70);
    block_valid = 1'b1;
    first_block = 1'b0;
    cycle(1);
    block_valid = 1'b0;
    cycle(70);

    // Randomized traffic with occasional aborts and asynchronous resets.
    for (int i = 0; i < 2500; i++) begin
      block_valid = ($urandom_range(0, 3) != 0);
      first_block = $urandom_range(0, 1) == 1;
      abort       = ($urandom_range(0, 80) == 0);
      if ($urandom_range(0, 600) == 0) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      cycle(1);
    end
    block_valid = 1'b0;
    abort = 1'b0;
    cycle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
